// File: rtl/mem_resp_pkg.sv
// Shared types and default widths for the mem_responder slice.
// The MEM_RESP_WRPROT_EN macro (write protection) is consumed by mem_responder.
package mem_resp_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      HOLD
   } state_e;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_e;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port storage for mem_responder: synchronous write, registered read.
// Contents have no reset so they survive a responder reset.
module mem_resp_array #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);
   import mem_resp_pkg::*;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Read data is registered every cycle from whatever address is presented.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Strobe-driven memory responder with fixed wait-state latency and a one-cycle ack.
// Define MEM_RESP_WRPROT_EN to drop writes to addresses at or below ROM_TOP.
module mem_responder #(
   parameter int                  ADDR_W      = mem_resp_pkg::ADDR_W,
   parameter int                  DATA_W      = mem_resp_pkg::DATA_W,
   parameter int                  DEPTH       = 256,
   parameter int                  WAIT_CYCLES = 1,
   parameter logic [ADDR_W-1:0]   ROM_TOP     = 13'h00FF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              ack,
   output logic              busy,
   output logic              err
);
   import mem_resp_pkg::*;

   localparam int                AW        = $clog2(DEPTH);
   localparam logic [3:0]        WAIT_CNT  = 4'(WAIT_CYCLES);
   localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   state_e              state_q;
   op_e                 op_q;
   logic [3:0]          waitCnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   dataOut_q;
   logic                dataOe_q;
   logic                ack_q;
   logic                busy_q;
   logic                err_q;

   logic                outOfRange;
   logic                protHit;
   logic                strobeHeld;
   logic                memWe;
   logic [AW-1:0]       memAddr;
   logic [DATA_W-1:0]   memRdata;

   assign outOfRange = ({1'b0, addr_q} >= DEPTH_LIM);
   assign strobeHeld = (op_q == OP_WR) ? wr : rd;

`ifdef MEM_RESP_WRPROT_EN
   assign protHit = (op_q == OP_WR) && (addr_q <= ROM_TOP);
`else
   logic unused_rom_top_w;
   assign unused_rom_top_w = ^ROM_TOP;
   assign protHit          = 1'b0;
`endif

   // In IDLE the live address is presented so read data is ready even with zero wait states.
   assign memAddr = (state_q == IDLE) ? addr[AW-1:0] : addr_q[AW-1:0];
   assign memWe   = (state_q == ACCESS) && (op_q == OP_WR) && !outOfRange && !protHit;

   mem_resp_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (memWe),
      .addr_i  (memAddr),
      .wdata_i (wdata_q),
      .rdata_o (memRdata)
   );

   // Access FSM; ack and err default low so they only ever pulse for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_RD;
         waitCnt_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         dataOut_q <= '0;
         dataOe_q  <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd && wr) begin
                  err_q   <= 1'b1;
                  state_q <= HOLD;
               end else if (rd || wr) begin
                  addr_q    <= addr;
                  wdata_q   <= data_in;
                  op_q      <= wr ? OP_WR : OP_RD;
                  waitCnt_q <= WAIT_CNT;
                  busy_q    <= 1'b1;
                  state_q   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
               end
            end
            WAIT: begin
               if (!strobeHeld) begin
                  waitCnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  waitCnt_q <= waitCnt_q - 4'd1;
                  if (waitCnt_q == 4'd1) begin
                     state_q <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               ack_q   <= 1'b1;
               err_q   <= outOfRange || protHit;
               busy_q  <= 1'b0;
               state_q <= HOLD;
               if (op_q == OP_RD) begin
                  dataOe_q  <= 1'b1;
                  dataOut_q <= outOfRange ? '0 : memRdata;
               end
            end
            HOLD: begin
               if (!rd) begin
                  dataOe_q  <= 1'b0;
                  dataOut_q <= '0;
               end
               if (!rd && !wr) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data_out = dataOut_q;
   assign data_oe  = dataOe_q;
   assign ack      = ack_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule
